sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
Synthesizable run controller for processor-level benches and FPGA bring-up. It replaces ad-hoc reset delays and fixed `$finish` timers with a single-clock block that:
- sequences the processor reset;
- counts run cycles;
- terminates the run on a signature write (pass/fail), a bus stall (halt) or a cycle budget (timeout).

It sits between the bench/top level and proc. It observes the proc memory-bus outputs and drives proc's reset.

Parameters:
- ADDR_W, 16, processor address bus width.
- DATA_W, 8, processor data bus width.
- CNT_W, 32, cycle counter width.
- RESET_CYCLES, 4, cycles proc_resetn is held low after resetn deasserts; legal range 1..255.
- MAX_CYCLES, 2000, run-cycle budget before timeout; must be ≥2 and ≤2^CNT_W-1.
- HALT_CYCLES, 16, consecutive cycles of unchanged address with no write that declare a halt; 0 disables halt detection.
- SIG_ADDR, 16'h0200, signature (mailbox) address.
- PASS_CODE, 8'h00, data value written to SIG_ADDR meaning pass.
- HOLD_ON_DONE, 1, when 1 proc_resetn returns low in any terminal state.

Ports:
- clk, in, 1, single clock shared with proc.
- resetn, in, 1, synchronous, active-low reset.
- address, in, ADDR_W, proc address bus.
- wr_data, in, DATA_W, proc write data.
- wr_enable, in, 1, proc write strobe.
- proc_resetn, out, 1, reset to proc (synchronous, active-low).
- state, out, 3, current FSM state encoding.
- done, out, 1, any terminal state reached.
- pass, out, 1, PASS_CODE written to SIG_ADDR.
- fail, out, 1, other value written to SIG_ADDR.
- halted, out, 1, bus stall detected.
- timeout, out, 1, cycle budget exhausted.
- result_code, out, DATA_W, data of the terminating signature write.
- cycle_count, out, CNT_W, RUN cycles elapsed.

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - resetn=0 sampled on a rising edge forces, at that edge: state=HOLD, proc_resetn=0, all flags=0, result_code=0, cycle_count=0, hold and halt counters=0.
  - This applies in any state, including mid-run and terminal states.
- State encoding: HOLD=0, RUN=1, PASS=2, FAIL=3, HALT=4, TIMEOUT=5.
- HOLD:
  - hold_cnt increments each cycle with resetn=1.
  - When hold_cnt==RESET_CYCLES-1, the next state is RUN and proc_resetn is registered to 1 on the same edge.
  - proc_resetn therefore rises exactly RESET_CYCLES edges after the first edge that samples resetn=1.
  - Bus inputs are ignored in HOLD.
- RUN:
  - cycle_count increments by 1 each RUN cycle, including the terminating cycle.
  - cycle_count saturates at all-ones and never wraps.
- Signature write (wr_enable=1 and address==SIG_ADDR):
  - result_code<=wr_data.
  - If wr_data==PASS_CODE, go to PASS and set pass=1; otherwise go to FAIL and set fail=1.
  - The flag is set on the same edge that samples the write.
- Halt detection:
  - prev_addr registers address every RUN cycle.
  - halt_cnt resets to 0 on the first RUN cycle, when address!=prev_addr, or when wr_enable=1; otherwise it increments.
  - When halt_cnt reaches HALT_CYCLES-1 with the address still unchanged, go to HALT and set halted=1.
  - Disabled when HALT_CYCLES==0.
- Timeout: in the RUN cycle where cycle_count==MAX_CYCLES-1 before increment (i.e. the MAX_CYCLES-th RUN cycle), go to TIMEOUT and set timeout=1.
- Simultaneous events in one cycle: priority is signature write > halt > timeout. Exactly one flag is ever set.
- Terminal states (PASS, FAIL, HALT, TIMEOUT):
  - Sticky until resetn=0.
  - done=1.
  - cycle_count, result_code and flags are frozen.
  - Bus inputs are ignored.
  - proc_resetn<=0 on the entry edge if HOLD_ON_DONE=1; otherwise it stays 1.
- done equals OR of pass, fail, halted and timeout. All outputs are registered; there are no combinational input-to-output paths.
- Writes to any address other than SIG_ADDR have no effect other than clearing halt_cnt.

Test Plan:
- Reset sequencing, RESET_CYCLES=4: deassert resetn at edge 0 -> proc_resetn=1 after edge 4, state=RUN, cycle_count=0 then increments; reassert resetn mid-RUN at cycle 50 -> next edge all outputs return to reset values, state=HOLD.
- Pass: write 8'h00 to 16'h0200 in RUN cycle 37 -> pass=1, done=1, state=2, result_code=8'h00, cycle_count=37; proc_resetn=0 next edge (HOLD_ON_DONE=1); further bus activity changes nothing.
- Fail: write 8'h5A to 16'h0200 -> fail=1, result_code=8'h5A, pass=0; write 8'h5A to 16'h0201 instead -> no transition.
- Halt, HALT_CYCLES=16: address held at 16'hC00F with no writes -> halted=1 on the 16th consecutive unchanged cycle; a write at 16'h0300 in cycle 10 of the stall restarts the count. HALT_CYCLES=0 -> never halts.
- Timeout and priority, MAX_CYCLES=100: toggle address every cycle -> timeout=1, cycle_count=100. Repeat with a signature write 8'h01 in cycle 100 -> fail=1 and timeout=0. CNT_W=4 with MAX_CYCLES=15 -> timeout at count 15 with no wrap.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Run controller for processor benches: sequences proc reset, counts run cycles and
// ends the run on a signature write (pass/fail), a bus stall (halt) or a cycle budget.
module sim_run_ctrl #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       CNT_W        = 32,
  parameter int unsigned       RESET_CYCLES = 4,
  parameter int unsigned       MAX_CYCLES   = 2000,
  parameter int unsigned       HALT_CYCLES  = 16,
  parameter logic [ADDR_W-1:0] SIG_ADDR     = 16'h0200,
  parameter logic [DATA_W-1:0] PASS_CODE    = 8'h00,
  parameter bit                HOLD_ON_DONE = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_enable,
  output logic              proc_resetn,
  output logic [2:0]        state,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              halted,
  output logic              timeout,
  output logic [DATA_W-1:0] result_code,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_HALT    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  localparam int unsigned       HALT_W    = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
  localparam bit                HALT_EN   = (HALT_CYCLES != 0);
  localparam logic [HALT_W-1:0] HALT_LAST = HALT_W'((HALT_CYCLES > 0) ? HALT_CYCLES - 1 : 0);
  localparam logic [7:0]        HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_e              state_q, state_d;
  logic [7:0]          hold_cnt_q, hold_cnt_d;
  logic [HALT_W-1:0]   halt_cnt_q, halt_cnt_d;
  logic [ADDR_W-1:0]   prev_addr_q, prev_addr_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic [DATA_W-1:0]   result_code_q, result_code_d;
  logic                proc_resetn_q, proc_resetn_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                halted_q, halted_d;
  logic                timeout_q, timeout_d;

  logic sig_hit, addr_same, halt_hit, tmo_hit;

  // cycle_count is zero only during the first RUN cycle, which has no previous address.
  assign sig_hit   = wr_enable && (address == SIG_ADDR);
  assign addr_same = (cycle_count_q != '0) && (address == prev_addr_q);
  assign halt_hit  = HALT_EN && addr_same && !wr_enable && (halt_cnt_q == HALT_LAST);
  assign tmo_hit   = (cycle_count_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    halt_cnt_d    = halt_cnt_q;
    prev_addr_d   = prev_addr_q;
    cycle_count_d = cycle_count_q;
    result_code_d = result_code_q;
    proc_resetn_d = proc_resetn_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d       = ST_RUN;
          proc_resetn_d = 1'b1;
        end
      end

      ST_RUN: begin
        prev_addr_d   = address;
        cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
        halt_cnt_d    = (HALT_EN && addr_same && !wr_enable) ? halt_cnt_q + 1'b1 : '0;

        // Priority: signature write, then halt, then timeout.
        if (sig_hit) begin
          result_code_d = wr_data;
          if (wr_data == PASS_CODE) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end
        end else if (halt_hit) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (tmo_hit) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end

        if (state_d != ST_RUN) begin
          done_d = 1'b1;
          if (HOLD_ON_DONE) proc_resetn_d = 1'b0;
        end
      end

      default: ;  // terminal states are sticky until resetn
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      halt_cnt_q    <= '0;
      prev_addr_q   <= '0;
      cycle_count_q <= '0;
      result_code_q <= '0;
      proc_resetn_q <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      halt_cnt_q    <= halt_cnt_d;
      prev_addr_q   <= prev_addr_d;
      cycle_count_q <= cycle_count_d;
      result_code_q <= result_code_d;
      proc_resetn_q <= proc_resetn_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      halted_q      <= halted_d;
      timeout_q     <= timeout_d;
    end
  end

  assign state       = state_q;
  assign proc_resetn = proc_resetn_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign result_code = result_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: three configurations share one bus; each is compared every cycle
// against an outcome computed from the recorded bus trace since reset release.
module tb_sim_run_ctrl;

  localparam logic [15:0] SIG  = 16'h0200;
  localparam logic [7:0]  PASS = 8'h00;

  // Per-instance configuration: main, no-halt/no-hold, narrow counter.
  localparam int RC  [3] = '{4, 4, 1};
  localparam int MC  [3] = '{100, 100, 15};
  localparam int HC  [3] = '{16, 0, 3};
  localparam bit HOD [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic [2:0]  state;
    logic        proc_resetn;
    logic        done;
    logic        pass;
    logic        fail;
    logic        halted;
    logic        timeout;
    logic [7:0]  result_code;
    logic [31:0] cycle_count;
  } obs_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_enable;

  logic [2:0]  st   [3];
  logic        prn  [3];
  logic        dn   [3];
  logic        ps   [3];
  logic        fl   [3];
  logic        hl   [3];
  logic        to   [3];
  logic [7:0]  code [3];
  logic [31:0] cc0, cc1;
  logic [3:0]  cc_small;
  obs_t        act  [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] h_addr [$];
  logic [7:0]  h_data [$];
  logic        h_we   [$];

  always #5 clk = ~clk;

  sim_run_ctrl #(.MAX_CYCLES(100), .HALT_CYCLES(16)) u_main (
    .clk(clk), .resetn(resetn), .address(address), .wr_data(wr_data), .wr_enable(wr_enable),
    .proc_resetn(prn[0]), .state(st[0]), .done(dn[0]), .pass(ps[0]), .fail(fl[0]),
    .halted(hl[0]), .timeout(to[0]), .result_code(code[0]), .cycle_count(cc0));

  sim_run_ctrl #(.MAX_CYCLES(100), .HALT_CYCLES(0), .HOLD_ON_DONE(1'b0)) u_nohalt (
    .clk(clk), .resetn(resetn), .address(address), .wr_data(wr_data), .wr_enable(wr_enable),
    .proc_resetn(prn[1]), .state(st[1]), .done(dn[1]), .pass(ps[1]), .fail(fl[1]),
    .halted(hl[1]), .timeout(to[1]), .result_code(code[1]), .cycle_count(cc1));

  sim_run_ctrl #(.CNT_W(4), .RESET_CYCLES(1), .MAX_CYCLES(15), .HALT_CYCLES(3)) u_small (
    .clk(clk), .resetn(resetn), .address(address), .wr_data(wr_data), .wr_enable(wr_enable),
    .proc_resetn(prn[2]), .state(st[2]), .done(dn[2]), .pass(ps[2]), .fail(fl[2]),
    .halted(hl[2]), .timeout(to[2]), .result_code(code[2]), .cycle_count(cc_small));

  always_comb begin
    act[0] = {st[0], prn[0], dn[0], ps[0], fl[0], hl[0], to[0], code[0], cc0};
    act[1] = {st[1], prn[1], dn[1], ps[1], fl[1], hl[1], to[1], code[1], cc1};
    act[2] = {st[2], prn[2], dn[2], ps[2], fl[2], hl[2], to[2], code[2], 28'd0, cc_small};
  end

  // Expected outputs of instance d after the edges recorded so far: replay the trace,
  // find the first terminating event among the RUN cycles, report the resulting state.
  function automatic obs_t model(input int d);
    obs_t e;
    int   n_run, streak, i;
    e = '0;
    if (h_addr.size() < RC[d]) return e;
    n_run         = h_addr.size() - RC[d];
    e.state       = 3'd1;
    e.proc_resetn = 1'b1;
    streak        = 0;
    for (int k = 1; k <= n_run; k++) begin
      i             = RC[d] + k - 1;
      e.cycle_count = 32'(k);
      if (k > 1 && h_addr[i] == h_addr[i-1] && !h_we[i]) streak++;
      else streak = 0;
      if (h_we[i] && h_addr[i] == SIG) begin
        e.result_code = h_data[i];
        if (h_data[i] == PASS) begin e.state = 3'd2; e.pass = 1'b1; end
        else                   begin e.state = 3'd3; e.fail = 1'b1; end
      end else if (HC[d] != 0 && streak == HC[d]) begin
        e.state = 3'd4; e.halted = 1'b1;
      end else if (k == MC[d]) begin
        e.state = 3'd5; e.timeout = 1'b1;
      end
      if (e.state != 3'd1) begin
        e.done        = 1'b1;
        e.proc_resetn = !HOD[d];
        return e;
      end
    end
    return e;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d prn=%b done/pass/fail/halt/tmo=%b%b%b%b%b code=%h cnt=%0d",
                     o.state, o.proc_resetn, o.done, o.pass, o.fail, o.halted, o.timeout,
                     o.result_code, o.cycle_count);
  endfunction

  task automatic step();
    @(posedge clk);
    if (resetn) begin
      h_addr.push_back(address);
      h_data.push_back(wr_data);
      h_we.push_back(wr_enable);
    end else begin
      h_addr.delete();
      h_data.delete();
      h_we.delete();
    end
    #1;
  endtask

  task automatic drive_nosig();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == SIG) a = 16'h0201;
    address   = a;
    wr_data   = 8'($urandom);
    wr_enable = 1'($urandom);
  endtask

  task automatic test_reset();
    obs_t exp_o;
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_nosig();
      step();
      for (int d = 0; d < 3; d++) begin
        exp_o = model(d);
        n_checks++;
        if (act[d] !== exp_o) $display("FAIL reset dut%0d edge%0d got %s expected %s", d, c, fmt(act[d]), fmt(exp_o));
        else n_pass++;
      end
    end
    resetn = 1'b1;
    for (int c = 0; c < 55; c++) begin
      if (c == 54) resetn = 1'b0;
      drive_nosig();
      step();
      for (int d = 0; d < 3; d++) begin
        exp_o = model(d);
        n_checks++;
        if (act[d] !== exp_o) $display("FAIL reset_seq dut%0d edge%0d got %s expected %s", d, c, fmt(act[d]), fmt(exp_o));
        else n_pass++;
      end
      if (c == 2) begin
        n_checks++;
        if (prn[0] !== 1'b0) $display("FAIL proc_resetn_early got %b expected 0", prn[0]);
        else n_pass++;
      end
      if (c == 3) begin
        n_checks++;
        if (prn[0] !== 1'b1 || st[0] !== 3'd1 || cc0 !== 32'd0)
          $display("FAIL run_entry got prn=%b st=%0d cnt=%0d expected prn=1 st=1 cnt=0", prn[0], st[0], cc0);
        else n_pass++;
      end
    end
    n_checks++;
    if (st[0] !== 3'd0 || prn[0] !== 1'b0 || cc0 !== 32'd0)
      $display("FAIL midrun_reset got st=%0d prn=%b cnt=%0d expected st=0 prn=0 cnt=0", st[0], prn[0], cc0);
    else n_pass++;
  endtask

  task automatic test_pass();
    obs_t exp_o;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int c = 0; c < 52; c++) begin
      if (c == 40) begin
        address = SIG; wr_data = PASS; wr_enable = 1'b1;
      end else if (c > 40) begin
        address = $urandom_range(0, 1) ? SIG : 16'($urandom);
        wr_data = 8'($urandom); wr_enable = 1'b1;
      end else begin
        drive_nosig();
      end
      step();
      for (int d = 0; d < 3; d++) begin
        exp_o = model(d);
        n_checks++;
        if (act[d] !== exp_o) $display("FAIL pass dut%0d edge%0d got %s expected %s", d, c, fmt(act[d]), fmt(exp_o));
        else n_pass++;
      end
      if (c == 40 || c == 51) begin
        n_checks++;
        if (ps[0] !== 1'b1 || dn[0] !== 1'b1 || st[0] !== 3'd2 || code[0] !== 8'h00 || cc0 !== 32'd37 || prn[0] !== 1'b0)
          $display("FAIL pass_at_37 got %s expected pass at cnt=37 prn=0", fmt(act[0]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_fail();
    obs_t exp_o;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 8) begin
        address = 16'h0201; wr_data = 8'h5A; wr_enable = 1'b1;
      end else if (c == 23) begin
        address = SIG; wr_data = 8'h5A; wr_enable = 1'b1;
      end else begin
        drive_nosig();
      end
      step();
      for (int d = 0; d < 3; d++) begin
        exp_o = model(d);
        n_checks++;
        if (act[d] !== exp_o) $display("FAIL fail dut%0d edge%0d got %s expected %s", d, c, fmt(act[d]), fmt(exp_o));
        else n_pass++;
      end
      if (c == 8) begin
        n_checks++;
        if (st[0] !== 3'd1 || dn[0] !== 1'b0) $display("FAIL near_sig_addr got %s expected still RUN", fmt(act[0]));
        else n_pass++;
      end
      if (c == 23) begin
        n_checks++;
        if (fl[0] !== 1'b1 || ps[0] !== 1'b0 || code[0] !== 8'h5A || st[0] !== 3'd3)
          $display("FAIL fail_code got %s expected fail code=5a", fmt(act[0]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_halt();
    obs_t exp_o;
    int   k;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      k = c - 3;
      if (k == 10) begin
        address = 16'h0300; wr_data = 8'($urandom); wr_enable = 1'b1;
      end else begin
        address = 16'hC00F; wr_data = 8'($urandom); wr_enable = 1'b0;
      end
      step();
      for (int d = 0; d < 3; d++) begin
        exp_o = model(d);
        n_checks++;
        if (act[d] !== exp_o) $display("FAIL halt dut%0d edge%0d got %s expected %s", d, c, fmt(act[d]), fmt(exp_o));
        else n_pass++;
      end
      if (k == 26) begin
        n_checks++;
        if (st[0] !== 3'd1) $display("FAIL halt_early got %s expected RUN", fmt(act[0]));
        else n_pass++;
      end
      if (k == 27) begin
        n_checks++;
        if (hl[0] !== 1'b1 || st[0] !== 3'd4 || cc0 !== 32'd27 || dn[0] !== 1'b1)
          $display("FAIL halt_at_27 got %s expected halted cnt=27", fmt(act[0]));
        else n_pass++;
      end
    end
    n_checks++;
    if (st[1] !== 3'd1 || hl[1] !== 1'b0) $display("FAIL halt_disabled got st=%0d halted=%b expected st=1 halted=0", st[1], hl[1]);
    else n_pass++;
  endtask

  // mode 0: plain timeout; mode 1: signature write on the timeout cycle;
  // mode 2: stall that completes exactly on the timeout cycle.
  task automatic test_timeout();
    obs_t exp_o;
    int   k;
    for (int mode = 0; mode < 3; mode++) begin
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int c = 0; c < 108; c++) begin
        k = c - 3;
        address   = k[0] ? 16'hA5A5 : 16'h5A5A;
        wr_data   = 8'($urandom);
        wr_enable = 1'b0;
        if (mode == 1 && k == 100) begin
          address = SIG; wr_data = 8'h01; wr_enable = 1'b1;
        end
        if (mode == 2 && k >= 84) address = 16'h1234;
        step();
        for (int d = 0; d < 3; d++) begin
          exp_o = model(d);
          n_checks++;
          if (act[d] !== exp_o) $display("FAIL timeout m%0d dut%0d edge%0d got %s expected %s", mode, d, c, fmt(act[d]), fmt(exp_o));
          else n_pass++;
        end
        if (k == 100) begin
          n_checks++;
          if (cc0 !== 32'd100 || dn[0] !== 1'b1 || to[0] !== (mode == 0) || fl[0] !== (mode == 1) || hl[0] !== (mode == 2))
            $display("FAIL priority m%0d got %s expected one flag at cnt=100", mode, fmt(act[0]));
          else n_pass++;
        end
      end
      n_checks++;
      if (cc_small !== 4'd15 || to[2] !== 1'b1) $display("FAIL narrow_count got cnt=%0d tmo=%b expected 15 1", cc_small, to[2]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp_o;
    int   pick, stall_pct;
    for (int run = 0; run < 4; run++) begin
      stall_pct = run[0] ? 95 : 70;
      resetn = 1'b0;
      drive_nosig();
      step();
      resetn = 1'b1;
      for (int c = 0; c < 150; c++) begin
        resetn = !(run == 3 && c == 60);
        pick = $urandom_range(0, 99);
        wr_data = $urandom_range(0, 1) ? 8'h00 : 8'($urandom);
        if (pick < stall_pct) begin
          wr_enable = 1'b0;
        end else if (pick < 97) begin
          address   = 16'hC000 | 16'($urandom_range(0, 3));
          wr_enable = 1'($urandom);
        end else begin
          address   = (run == 1) ? 16'h0201 : SIG;
          wr_enable = 1'b1;
        end
        step();
        for (int d = 0; d < 3; d++) begin
          exp_o = model(d);
          n_checks++;
          if (act[d] !== exp_o) $display("FAIL random r%0d dut%0d edge%0d got %s expected %s", run, d, c, fmt(act[d]), fmt(exp_o));
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    address   = '0;
    wr_data   = '0;
    wr_enable = 1'b0;
    test_reset();
    test_pass();
    test_fail();
    test_halt();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
